// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word load/store responder that stalls the CPU until a single-cycle response is returned
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        stall_o
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  if (LATENCY < 1) begin : g_latency_check
    $error("dmem_responder: LATENCY must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic          cap_write, cap_err;
  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_wdata;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          accept, req_err;
  assign accept  = state == IDLE && req_valid_i;
  // full 30-bit word index compare, so high addresses never alias into the array
  assign req_err = req_addr_i[1:0] != 2'b00 || {2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS);
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = req_valid_i ? WAIT : IDLE;
      WAIT:    state_nx = cnt == '0 ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready_o = state == IDLE;
    rsp_valid_o = state == RESP;
    stall_o     = accept || state == WAIT;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      cnt         <= '0;
      cap_write   <= 1'b0;
      cap_err     <= 1'b0;
      cap_idx     <= '0;
      cap_wdata   <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        cap_write <= req_write_i;
        cap_err   <= req_err;
        cap_idx   <= req_addr_i[2 +: AW];
        cap_wdata <= req_wdata_i;
        cnt       <= CW'(LATENCY - 1);
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0) begin
        if (cap_err) begin
          rsp_rdata_o <= '0;
          rsp_err_o   <= 1'b1;
        end else if (cap_write) mem[cap_idx] <= cap_wdata;
        else rsp_rdata_o <= mem[cap_idx];
      end
      if (state == RESP) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b0;
      end
    end
endmodule
